// File: rtl/io_responder.sv
// IO-page responder: decodes word offsets, serves combinational reads and clocked writes,
// and drives LEDs, synchronised switches, debounced buttons, a 7-segment scanner and a cycle timer.
module io_responder #(
  parameter int SCAN_DIV   = 50000,
  parameter int DEB_CYCLES = 200000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        io_en,
  input  logic        io_we,
  input  logic [11:0] io_addr,
  input  logic [31:0] io_write_data,
  output logic [31:0] io_read_data,
  input  logic [23:0] sw,
  input  logic [4:0]  btn,
  output logic [23:0] led,
  output logic [7:0]  dig_en,
  output logic [7:0]  seg
);

  localparam int SCAN_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W  = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_DIG,
    SEL_TIMER,
    SEL_LED,
    SEL_SW,
    SEL_BTN
  } sel_t;

  sel_t              sel;
  logic              wr;
  logic [31:0]       dig;
  logic [31:0]       timer;
  logic [23:0]       led_reg;
  logic [23:0]       sw_meta;
  logic [23:0]       sw_sync;
  logic [4:0]        btn_meta;
  logic [4:0]        btn_sync;
  logic [4:0]        btn_stable;
  logic [DEB_W-1:0]  deb_cnt [5];
  logic [SCAN_W-1:0] scan_cnt;
  logic [2:0]        idx;
  logic [3:0]        nibble;

  // Byte-lane bits [1:0] are don't-care so every register aliases across its word.
  always_comb begin
    sel = SEL_NONE;
    casez (io_addr)
      12'b0000_0000_00??: sel = SEL_DIG;
      12'b0000_0101_00??: sel = SEL_TIMER;
      12'b0000_0110_00??: sel = SEL_LED;
      12'b0000_0111_00??: sel = SEL_SW;
      12'b0000_0111_10??: sel = SEL_BTN;
      default:            sel = SEL_NONE;
    endcase
  end

  assign wr = io_en & io_we;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dig     <= '0;
      led_reg <= '0;
      timer   <= '0;
    end else begin
      if (wr && sel == SEL_DIG) dig <= io_write_data;
      if (wr && sel == SEL_LED) led_reg <= io_write_data[23:0];
      if (wr && sel == SEL_TIMER) timer <= io_write_data;
      else                        timer <= timer + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sw_meta  <= '0;
      sw_sync  <= '0;
      btn_meta <= '0;
      btn_sync <= '0;
    end else begin
      sw_meta  <= sw;
      sw_sync  <= sw_meta;
      btn_meta <= btn;
      btn_sync <= btn_meta;
    end
  end

  // A new button level is accepted only after it has disagreed with the stable copy for DEB_CYCLES cycles in a row.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_stable <= '0;
      for (int i = 0; i < 5; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (btn_sync[i] != btn_stable[i]) begin
          if (deb_cnt[i] == DEB_LAST) begin
            btn_stable[i] <= btn_sync[i];
            deb_cnt[i]    <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      idx      <= idx + 3'd1;
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
    end
  end

  assign dig_en = ~(8'b1 << idx);
  assign nibble = dig[{idx, 2'b00} +: 4];

  always_comb begin
    seg = 8'hFF;
    case (nibble)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      4'hF: seg = 8'h8E;
      default: seg = 8'hFF;
    endcase
  end

  always_comb begin
    io_read_data = 32'h0;
    if (io_en && !io_we) begin
      case (sel)
        SEL_DIG:   io_read_data = dig;
        SEL_TIMER: io_read_data = timer;
        SEL_LED:   io_read_data = {8'h0, led_reg};
        SEL_SW:    io_read_data = {8'h0, sw_sync};
        SEL_BTN:   io_read_data = {27'h0, btn_stable};
        default:   io_read_data = 32'h0;
      endcase
    end
  end

  assign led = led_reg;

endmodule

// File: tb/tb_io_responder.sv
// Directed bench for io_responder with short scan and debounce periods.
module tb_io_responder;

  logic        clk;
  logic        rst_n;
  logic        io_en;
  logic        io_we;
  logic [11:0] io_addr;
  logic [31:0] io_write_data;
  logic [31:0] io_read_data;
  logic [23:0] sw;
  logic [4:0]  btn;
  logic [23:0] led;
  logic [7:0]  dig_en;
  logic [7:0]  seg;

  int checks = 0;
  int errors = 0;

  io_responder #(.SCAN_DIV(4), .DEB_CYCLES(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .io_en         (io_en),
    .io_we         (io_we),
    .io_addr       (io_addr),
    .io_write_data (io_write_data),
    .io_read_data  (io_read_data),
    .sw            (sw),
    .btn           (btn),
    .led           (led),
    .dig_en        (dig_en),
    .seg           (seg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic en, input logic we, input logic [11:0] addr,
                                input logic [31:0] data);
    io_en         = en;
    io_we         = we;
    io_addr       = addr;
    io_write_data = data;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic read_check(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    apply_stimulus(1'b1, 1'b0, addr, 32'h0);
    #1;
    check_output(tag, io_read_data, exp);
  endtask

  // Resets, loads DIG on the first free edge, then walks one full refresh plus one digit.
  task automatic run_scan(input logic [31:0] value, input logic [63:0] glyphs);
    logic [2:0] idx_e;
    rst_n = 1'b0;
    apply_stimulus(1'b0, 1'b0, 12'h000, 32'h0);
    tick();
    tick();
    check_output("scan_reset_dig_en", {24'h0, dig_en}, 32'h0000_00FE);
    check_output("scan_reset_seg", {24'h0, seg}, 32'h0000_00C0);
    rst_n = 1'b1;
    apply_stimulus(1'b1, 1'b1, 12'h000, value);
    tick();
    apply_stimulus(1'b0, 1'b0, 12'h000, 32'h0);
    for (int k = 1; k <= 33; k++) begin
      idx_e = 3'((k / 4) % 8);
      check_output("scan_dig_en", {24'h0, dig_en}, {24'h0, ~(8'b1 << idx_e)});
      check_output("scan_seg", {24'h0, seg}, {24'h0, glyphs[idx_e*8 +: 8]});
      if (k == 1) read_check("dig_read", 12'h000, value);
      apply_stimulus(1'b0, 1'b0, 12'h000, 32'h0);
      if (k != 33) tick();
    end
  endtask

  initial begin
    logic [31:0] btn_exp;
    clk   = 1'b0;
    rst_n = 1'b0;
    sw    = '0;
    btn   = '0;
    apply_stimulus(1'b0, 1'b0, 12'h000, 32'h0);

    $display("[TB] reset");
    tick();
    tick();
    check_output("reset_led", {8'h0, led}, 32'h0);
    check_output("reset_dig_en", {24'h0, dig_en}, 32'h0000_00FE);
    check_output("reset_seg", {24'h0, seg}, 32'h0000_00C0);
    read_check("reset_dig", 12'h000, 32'h0);
    read_check("reset_timer", 12'h050, 32'h0);
    read_check("reset_led_read", 12'h060, 32'h0);
    rst_n = 1'b1;

    $display("[TB] switch synchroniser");
    sw = 24'hA5C35A;
    tick();
    read_check("sw_one_edge", 12'h070, 32'h0);
    tick();
    read_check("sw_two_edges", 12'h070, 32'h00A5_C35A);

    $display("[TB] LED register");
    apply_stimulus(1'b1, 1'b1, 12'h060, 32'hAB12_3456);
    tick();
    apply_stimulus(1'b0, 1'b0, 12'h000, 32'h0);
    check_output("led_out", {8'h0, led}, 32'h0012_3456);
    read_check("led_read", 12'h060, 32'h0012_3456);
    read_check("led_alias", 12'h063, 32'h0012_3456);
    apply_stimulus(1'b1, 1'b1, 12'h070, 32'hFFFF_FFFF);
    tick();
    read_check("sw_ro", 12'h070, 32'h00A5_C35A);

    $display("[TB] read gating and unmapped");
    apply_stimulus(1'b0, 1'b0, 12'h060, 32'h0);
    #1;
    check_output("read_en_low", io_read_data, 32'h0);
    apply_stimulus(1'b1, 1'b1, 12'h060, 32'h0012_3456);
    #1;
    check_output("read_we_high", io_read_data, 32'h0);
    apply_stimulus(1'b0, 1'b1, 12'h060, 32'h00FF_FFFF);
    tick();
    check_output("no_write_en_low", {8'h0, led}, 32'h0012_3456);
    apply_stimulus(1'b1, 1'b1, 12'h100, 32'hDEAD_BEEF);
    tick();
    read_check("unmapped_read", 12'h100, 32'h0);
    read_check("unmapped_led", 12'h060, 32'h0012_3456);
    read_check("unmapped_dig", 12'h000, 32'h0);
    apply_stimulus(1'b1, 1'b1, 12'h000, 32'h89AB_CDEF);
    tick();
    read_check("dig_write", 12'h000, 32'h89AB_CDEF);
    check_output("dig_seg", {24'h0, seg}, {24'h0, (dig_en == 8'hFE) ? 8'h8E :
                 (dig_en == 8'hFD) ? 8'h86 : (dig_en == 8'hFB) ? 8'hA1 :
                 (dig_en == 8'hF7) ? 8'hC6 : (dig_en == 8'hEF) ? 8'h83 :
                 (dig_en == 8'hDF) ? 8'h88 : (dig_en == 8'hBF) ? 8'h90 : 8'h80});

    $display("[TB] timer wrap");
    apply_stimulus(1'b1, 1'b1, 12'h050, 32'hFFFF_FFFE);
    tick();
    read_check("timer_load", 12'h050, 32'hFFFF_FFFE);
    tick();
    read_check("timer_max", 12'h050, 32'hFFFF_FFFF);
    tick();
    read_check("timer_wrap", 12'h050, 32'h0000_0000);
    tick();
    read_check("timer_after_wrap", 12'h050, 32'h0000_0001);

    $display("[TB] button glitch");
    btn = 5'b00100;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 5) btn = 5'b00000;
      read_check("btn_glitch", 12'h078, 32'h0);
    end

    $display("[TB] button hold and release");
    btn = 5'b00100;
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (k == 12) btn = 5'b00000;
      btn_exp = (k >= 10 && k < 22) ? 32'h4 : 32'h0;
      read_check("btn_debounce", 12'h078, btn_exp);
    end

    $display("[TB] scanner");
    run_scan(32'h0123_4567, 64'hC0F9_A4B0_9992_82F8);
    apply_stimulus(1'b1, 1'b1, 12'h000, 32'h0000_000A);
    tick();
    apply_stimulus(1'b0, 1'b0, 12'h000, 32'h0);
    check_output("mid_dwell_seg", {24'h0, seg}, 32'h0000_0088);
    check_output("mid_dwell_dig_en", {24'h0, dig_en}, 32'h0000_00FE);
    tick();
    check_output("mid_dwell_hold", {24'h0, dig_en}, 32'h0000_00FE);
    tick();
    check_output("mid_dwell_next_dig_en", {24'h0, dig_en}, 32'h0000_00FD);
    check_output("mid_dwell_next_seg", {24'h0, seg}, 32'h0000_00C0);
    run_scan(32'h89AB_CDEF, 64'h8090_8883_C6A1_868E);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_responder.md
# io_responder

Memory-mapped IO peripheral that answers the CPU-side bus decoder on the IO page (CPU address bits [31:12] equal to the IO page constant). It decodes the 12-bit IO offset, serves single-cycle combinational reads and clocked word writes, and owns the board peripherals: LEDs, switches, debounced buttons, an 8-digit seven-segment display scanner and a free-running cycle timer. It sits between the bus decoder's IO-side signals and the board pins.

## Interface
Parameters:
- SCAN_DIV, 50000: clock cycles each seven-segment digit stays lit (>=2).
- DEB_CYCLES, 200000: cycles a synchronised button level must hold before it is accepted (>=2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset; the only clock is clk.
- io_en  in  1  access targets the IO page.
- io_we  in  1  write strobe (bus write qualified by io_en).
- io_addr  in  12  IO offset (CPU address bits [11:0]).
- io_write_data  in  32  write data.
- io_read_data  out  32  read data, combinational.
- sw  in  24  board switches, asynchronous.
- btn  in  5  board push buttons, asynchronous, active-high.
- led  out  24  LED drive, active-high.
- dig_en  out  8  digit enables, active-low, one-hot-zero.
- seg  out  8  segments {DP,G,F,E,D,C,B,A}, active-low.

## Operation
- Register map (word access only; io_addr[1:0] ignored in decode):
  - 0x000 DIG: R/W, 32 bits; nibble i shown on digit i (digit 0 = bits [3:0]).
  - 0x050 TIMER: R/W, 32 bits; increments by 1 every cycle, wraps 0xFFFF_FFFF -> 0.
  - 0x060 LED: R/W, low 24 bits; bits [31:24] write-ignored, read 0.
  - 0x070 SW: RO, {8'h0, sw_sync}.
  - 0x078 BTN: RO, {27'h0, btn_stable}.
  - Any other offset: reads 0, writes ignored.
- Write: on rising clk edge when rst_n=1, io_en=1, io_we=1 and offset is a R/W register. Writes to RO/unmapped offsets have no effect.
- Read: io_read_data = selected register whenever io_en=1 and io_we=0; 32'h0 otherwise (io_en=0 or io_we=1). No read side effects.
- TIMER write on same edge as increment: written value loads; increment resumes next cycle.
- sw: two-flop synchroniser per bit -> sw_sync.
- btn: two-flop synchroniser, then per-bit debounce counter: if synced != btn_stable, counter increments; when counter reaches DEB_CYCLES-1 with mismatch still present, btn_stable takes synced and counter clears; any cycle with synced == btn_stable clears counter.
- Scanner: scan_cnt counts 0..SCAN_DIV-1 and wraps; on wrap, digit index idx (3 bits) increments mod 8. dig_en = ~(8'b1 << idx). seg[6:0] = active-low hex glyph of DIG nibble idx (0=C0,1=F9,2=A4,3=B0,4=99,5=92,6=82,7=F8,8=80,9=90,A=88,b=83,C=C6,d=A1,E=86,F=8E, given as seg[7:0] with DP=1). DP always 1 (off).
- led = LED register directly.

## Timing
- Reset (rst_n=0 at edge), values after that edge: DIG=0, LED=0, TIMER=0, sw_sync=0, btn_stable=0, debounce counters=0, scan_cnt=0, idx=0; outputs led=0, dig_en=8'hFE, seg=8'hC0. Reset mid-scan or mid-debounce discards progress.
- Write latency: register value visible on io_read_data and led/seg the cycle after the write edge.
- Read latency: zero cycles (combinational from io_addr/io_en/io_we), matching the single-cycle CPU.
- sw change visible at SW read 2 edges after sampling.
- btn change accepted 2 (sync) + DEB_CYCLES edges after a clean level change; glitches shorter than DEB_CYCLES cycles never reach btn_stable.
- Digit dwell exactly SCAN_DIV cycles; full refresh 8*SCAN_DIV cycles; idx 7 wraps to 0.
- Display value update mid-dwell changes seg immediately on next cycle without resetting scan_cnt.

## Test plan
- Reset: hold rst_n=0 two cycles -> led=0, dig_en=FE, seg=C0, reads of 0x000/0x050/0x060 return 0.
- Write LED 0xAB12_3456 at 0x060 -> led=0x12_3456 next cycle; read 0x060 returns 0x0012_3456; write to 0x070 leaves SW read unchanged.
- SCAN_DIV=4, write DIG=0x0123_4567 -> digit 0 seg=F8 (7) for 4 cycles, then dig_en=FD seg=82 (6), ..., idx 7 shows C0, then wraps to FE.
- DEB_CYCLES=8: btn[2] pulse 5 cycles -> BTN reads 0; hold 12 cycles -> BTN reads 0x4 after 2+8 edges, returns 0 after equal-length release.
- TIMER: write 0xFFFF_FFFE at 0x050 -> reads 0xFFFF_FFFF, 0x0, 0x1 on following cycles.
- io_en=0 or io_we=1 with io_addr=0x060 -> io_read_data=0; io_en=0,io_we=1 -> no register changes; unmapped 0x100 read -> 0.
